// File: rtl/change_dispenser.sv
// Coin-chute sequencer: dispenses latched dime/nickel counts one coin at a time,
// dimes first, confirming each coin on the chute sensor before ejecting the next.
module change_dispenser #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 50,
  parameter int unsigned CW           = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [CW-1:0] dime_req,
  input  logic [CW-1:0] nickel_req,
  input  logic          coin_seen,
  input  logic          clear_err,
  output logic          eject_dime,
  output logic          eject_nickel,
  output logic          busy,
  output logic          done,
  output logic          jam,
  output logic [CW-1:0] dimes_left,
  output logic [CW-1:0] nickels_left
);

  localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, D_PULSE, D_WAIT, N_PULSE, N_WAIT, DONE, JAM
  } state_t;

  state_t        state;
  logic [PW-1:0] pulse_cnt;
  logic [TW-1:0] tmo_cnt;

  // Outputs are registered alongside the state transition, so each branch
  // sets the output values that belong to the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      pulse_cnt    <= '0;
      tmo_cnt      <= '0;
      eject_dime   <= 1'b0;
      eject_nickel <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      jam          <= 1'b0;
      dimes_left   <= '0;
      nickels_left <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dimes_left   <= dime_req;
            nickels_left <= nickel_req;
            busy         <= 1'b1;
            pulse_cnt    <= '0;
            if (dime_req != '0) begin
              state      <= D_PULSE;
              eject_dime <= 1'b1;
            end else if (nickel_req != '0) begin
              state        <= N_PULSE;
              eject_nickel <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        D_PULSE: begin
          if (pulse_cnt == PULSE_LAST) begin
            state      <= D_WAIT;
            eject_dime <= 1'b0;
            tmo_cnt    <= '0;
          end else begin
            pulse_cnt <= pulse_cnt + PW'(1);
          end
        end

        D_WAIT: begin
          if (coin_seen) begin
            dimes_left <= dimes_left - CW'(1);
            pulse_cnt  <= '0;
            // dimes_left is still the pre-decrement value here
            if (dimes_left != CW'(1)) begin
              state      <= D_PULSE;
              eject_dime <= 1'b1;
            end else if (nickels_left != '0) begin
              state        <= N_PULSE;
              eject_nickel <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state <= JAM;
            jam   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        N_PULSE: begin
          if (pulse_cnt == PULSE_LAST) begin
            state        <= N_WAIT;
            eject_nickel <= 1'b0;
            tmo_cnt      <= '0;
          end else begin
            pulse_cnt <= pulse_cnt + PW'(1);
          end
        end

        N_WAIT: begin
          if (coin_seen) begin
            nickels_left <= nickels_left - CW'(1);
            pulse_cnt    <= '0;
            if (nickels_left != CW'(1)) begin
              state        <= N_PULSE;
              eject_nickel <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state <= JAM;
            jam   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        JAM: begin
          if (clear_err) begin
            state <= IDLE;
            busy  <= 1'b0;
            jam   <= 1'b0;
          end
        end

        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          jam          <= 1'b0;
          eject_dime   <= 1'b0;
          eject_nickel <= 1'b0;
        end
      endcase
    end
  end

endmodule
